// File: rtl/bcd_pkg.sv
// Shared BCD definitions: code widths, the "no line" constant and the
// one-hot decode function reused by display-side blocks.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam int DEC_W = 10;

    localparam logic [DEC_W-1:0] DEC_NONE = '0;

    // Decode one BCD digit to an active-high 1-of-10 line vector.
    // Codes 10..15 (and X/Z in simulation) assert no line.
    function automatic logic [DEC_W-1:0] bcd_to_onehot(input logic [BCD_W-1:0] bcd);
        logic [DEC_W-1:0] lines;
        lines = DEC_NONE;
        case (bcd)
            4'd0:    lines = 10'b0000000001;
            4'd1:    lines = 10'b0000000010;
            4'd2:    lines = 10'b0000000100;
            4'd3:    lines = 10'b0000001000;
            4'd4:    lines = 10'b0000010000;
            4'd5:    lines = 10'b0000100000;
            4'd6:    lines = 10'b0001000000;
            4'd7:    lines = 10'b0010000000;
            4'd8:    lines = 10'b0100000000;
            4'd9:    lines = 10'b1000000000;
            default: lines = DEC_NONE;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/bcd_to_decimal_beh.sv
// Registered BCD-to-decimal decoder: one output register, one clock of
// latency, no combinational path from BCDIn to DECOut.
module bcd_to_decimal_beh
    import bcd_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic [BCD_W-1:0] BCDIn,
    output logic [DEC_W-1:0] DECOut
);

    // Output register: synchronous clear has priority, otherwise load the decode.
    // NOTE: nRST is absent from the sensitivity list, so the clear only takes
    // effect on a rising CLK edge; a glitch between edges is ignored.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            DECOut <= DEC_NONE;
        end else begin
            DECOut <= bcd_to_onehot(BCDIn);
        end
    end

endmodule

// File: tb/tb_bcd_to_decimal_beh.sv
// Scoreboard bench for bcd_to_decimal_beh: the driver pushes the expected
// register value for every edge it drives; the monitor pops after each edge.
module tb_bcd_to_decimal_beh;

    logic       CLK;
    logic       nRST;
    logic [3:0] BCDIn;
    logic [9:0] DECOut;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];

    // Hand-written decode table for codes 0..15.
    logic [9:0] sweep_exp [16] = '{
        10'b0000000001, 10'b0000000010, 10'b0000000100, 10'b0000001000,
        10'b0000010000, 10'b0000100000, 10'b0001000000, 10'b0010000000,
        10'b0100000000, 10'b1000000000, 10'b0000000000, 10'b0000000000,
        10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000
    };

    bcd_to_decimal_beh dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .BCDIn  (BCDIn),
        .DECOut (DECOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge's inputs on the falling edge and record the expected result.
    task automatic drive(input logic rst_n, input logic [3:0] bcd, input logic [9:0] exp);
        @(negedge CLK);
        nRST  = rst_n;
        BCDIn = bcd;
        exp_q.push_back(exp);
    endtask

    // Monitor: the register updates every edge, so each edge is an output event.
    initial begin
        logic [9:0] exp;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("decode", DECOut, exp);
                check("onehot", {9'b0, ($countones(DECOut) <= 1)}, 10'b1);
            end
        end
    end

    initial begin
        logic [3:0] r;
        nRST  = 1'b0;
        BCDIn = 4'd5;

        // Reset hold for two edges with a valid code present.
        drive(1'b0, 4'd5, 10'b0);
        drive(1'b0, 4'd5, 10'b0);

        // Full sweep of all codes, then wrap to 0.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 4'(k), sweep_exp[k]);
        end
        drive(1'b1, 4'd0, 10'b0000000001);

        // Latency: input changes mid-cycle, output holds until the next edge.
        drive(1'b1, 4'd3, 10'b0000001000);
        @(posedge CLK);
        #2 BCDIn = 4'd7;
        #2 check("latency_hold", DECOut, 10'b0000001000);
        drive(1'b1, 4'd7, 10'b0010000000);

        // Reset priority mid-run, then recovery with the same input.
        drive(1'b1, 4'd9, 10'b1000000000);
        drive(1'b0, 4'd9, 10'b0000000000);
        drive(1'b1, 4'd9, 10'b1000000000);

        // Short reset pulse between edges must not clear the register.
        drive(1'b1, 4'd4, 10'b0000010000);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #2 nRST = 1'b1;
        #1 check("sync_only_pulse", DECOut, 10'b0000010000);
        drive(1'b1, 4'd4, 10'b0000010000);

        // Random codes; expected value from a shift rather than the table.
        for (int i = 0; i < 200; i++) begin
            r = 4'($urandom_range(0, 15));
            drive(1'b1, r, (r <= 4'd9) ? (10'b1 << r) : 10'b0);
        end

        // Let the monitor drain the scoreboard, bounded.
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
            @(posedge CLK);
            #2;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
